// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO PHY-side responder: decodes station frames into single-clk register strobes and drives read data.
// Optional MDIO_PREAMBLE_SUPPRESS_EN lets a frame start without a full preamble after a completed addressed frame.
module mdio_phy_responder #(
    parameter logic [4:0] PHY_ADDR     = 5'd1,
    parameter int         PREAMBLE_LEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_c,
    input  logic        md_in,
    output logic        md_out,
    output logic        md_oe,
    output logic [4:0]  reg_addr,
    output logic        reg_rd,
    input  logic [15:0] reg_rdata,
    output logic        reg_wr,
    output logic [15:0] reg_wdata
);

    localparam int PW = $clog2(PREAMBLE_LEN + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(PREAMBLE_LEN);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    localparam logic [PW-1:0] PRE_DONE = PRE_MAX;
`else
    localparam logic [PW-1:0] PRE_DONE = '0;
`endif

    typedef enum logic [2:0] {IDLE, ST2, OP, PHYAD, REGAD, TA, WDATA, RDATA} state_t;

    function automatic logic [PW-1:0] sat_inc(input logic [PW-1:0] c);
        if (c >= PRE_MAX)
            return PRE_MAX;
        return c + 1'b1;
    endfunction

    // md_c/md_in synchroniser; md_c_p2 is the previous synchronised md_c for edge detection
    logic md_c_p0, md_c_p1, md_c_p2;
    logic md_in_p0, md_in_p1;

    always_ff @(posedge clk) begin
        md_c_p0  <= md_c;
        md_c_p1  <= md_c_p0;
        md_c_p2  <= md_c_p1;
        md_in_p0 <= md_in;
        md_in_p1 <= md_in_p0;
    end

    logic rise, fall, sbit;
    assign rise = md_c_p1 & ~md_c_p2;
    assign fall = ~md_c_p1 & md_c_p2;
    assign sbit = md_in_p1;

    // frame decoder and read-data driver
    state_t         state;
    logic [4:0]     bit_cnt;
    logic [PW-1:0]  pre_cnt;
    logic           is_read;
    logic           op_first;
    logic [3:0]     phy_sh;
    logic [15:0]    rd_sh;
    logic           rd_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            pre_cnt   <= '0;
            is_read   <= 1'b0;
            rd_pend   <= 1'b0;
            md_oe     <= 1'b0;
            md_out    <= 1'b1;
            reg_rd    <= 1'b0;
            reg_wr    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
        end else begin
            reg_rd  <= 1'b0;
            reg_wr  <= 1'b0;
            rd_pend <= reg_rd;
            // register file answers one clk after the strobe
            if (rd_pend)
                rd_sh <= reg_rdata;

            case (state)
                IDLE: begin
                    if (rise) begin
                        if (sbit) begin
                            pre_cnt <= sat_inc(pre_cnt);
                        end else if (pre_cnt == PRE_MAX) begin
                            state   <= ST2;
                            pre_cnt <= '0;
                            bit_cnt <= '0;
                        end else begin
                            pre_cnt <= '0;
                        end
                    end
                end
                ST2: begin
                    if (rise) begin
                        state   <= sbit ? OP : IDLE;
                        bit_cnt <= '0;
                    end
                end
                OP: begin
                    if (rise) begin
                        if (bit_cnt == 5'd0) begin
                            op_first <= sbit;
                            bit_cnt  <= 5'd1;
                        end else begin
                            bit_cnt <= '0;
                            if (op_first != sbit) begin
                                is_read <= op_first;
                                state   <= PHYAD;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                PHYAD: begin
                    if (rise) begin
                        if (bit_cnt == 5'd4) begin
                            bit_cnt <= '0;
                            state   <= ({phy_sh, sbit} == PHY_ADDR) ? REGAD : IDLE;
                        end else begin
                            phy_sh  <= {phy_sh[2:0], sbit};
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                REGAD: begin
                    if (rise) begin
                        reg_addr <= {reg_addr[3:0], sbit};
                        if (bit_cnt == 5'd4) begin
                            bit_cnt <= '0;
                            state   <= TA;
                            reg_rd  <= is_read;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                TA: begin
                    // read: ignore the fall preceding TA bit 1, take the pad on the fall after it
                    if (is_read) begin
                        if (rise) begin
                            bit_cnt <= 5'd1;
                        end else if (fall && bit_cnt == 5'd1) begin
                            md_oe   <= 1'b1;
                            md_out  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= RDATA;
                        end
                    end else if (rise) begin
                        if (bit_cnt == 5'd1) begin
                            bit_cnt <= '0;
                            state   <= WDATA;
                        end else begin
                            bit_cnt <= 5'd1;
                        end
                    end
                end
                WDATA: begin
                    if (rise) begin
                        reg_wdata <= {reg_wdata[14:0], sbit};
                        if (bit_cnt == 5'd15) begin
                            reg_wr  <= 1'b1;
                            bit_cnt <= '0;
                            pre_cnt <= PRE_DONE;
                            state   <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                RDATA: begin
                    if (fall) begin
                        if (bit_cnt == 5'd16) begin
                            md_oe   <= 1'b0;
                            md_out  <= 1'b1;
                            bit_cnt <= '0;
                            pre_cnt <= PRE_DONE;
                            state   <= IDLE;
                        end else begin
                            md_out  <= rd_sh[15];
                            rd_sh   <= {rd_sh[14:0], 1'b0};
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Self-checking bench for mdio_phy_responder: bit-banged station frames, strobe scoreboard, pad sampling.
module tb_mdio_phy_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        md_c = 1'b0;
    logic        drv = 1'b1;
    logic        md_in, md_out, md_oe;
    logic [4:0]  reg_addr;
    logic        reg_rd, reg_wr;
    logic [15:0] reg_rdata, reg_wdata;
    logic [15:0] rd_value = 16'h0000;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    localparam bit SUPP = 1'b1;
`else
    localparam bit SUPP = 1'b0;
`endif

    always #5 clk = ~clk;

    // open-drain style pad: station releases to a pull-up (drv=1) when the PHY drives
    assign md_in = md_oe ? md_out : drv;

    // register file model: data valid exactly one clk after reg_rd, garbage otherwise
    always_ff @(posedge clk)
        reg_rdata <= reg_rd ? rd_value : 16'hDEAD;

    mdio_phy_responder #(.PHY_ADDR(5'd1), .PREAMBLE_LEN(32)) dut (
        .clk(clk), .reset(reset), .md_c(md_c), .md_in(md_in),
        .md_out(md_out), .md_oe(md_oe), .reg_addr(reg_addr), .reg_rd(reg_rd),
        .reg_rdata(reg_rdata), .reg_wr(reg_wr), .reg_wdata(reg_wdata)
    );

    typedef struct packed {
        logic        is_wr;
        logic [4:0]  addr;
        logic [15:0] data;
    } ev_t;

    typedef struct {
        bit          is_read;
        int          pre_n;
        logic [4:0]  phyad;
        logic [4:0]  regad;
        logic [15:0] data;
        bit          answer;
    } vec_t;

    ev_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic oe_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // one clk; every strobe is popped from the scoreboard and compared
    task automatic tick();
        ev_t e;
        @(negedge clk);
        if (md_oe === 1'b1)
            oe_seen = 1'b1;
        if (reg_rd || reg_wr) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {25'd0, reg_wr, reg_rd, reg_addr}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("strobe", {9'd0, reg_rd, reg_wr, reg_addr, reg_wr ? reg_wdata : 16'h0},
                      {9'd0, ~e.is_wr, e.is_wr, e.addr, e.is_wr ? e.data : 16'h0});
            end
        end
    endtask

    // one MDC period: station drives on the fall, samples the pad just before the rise
    task automatic mdc_cycle(input logic b, output logic oe_s, output logic out_s);
        md_c = 1'b0;
        drv  = b;
        repeat (6) tick();
        oe_s  = md_oe;
        out_s = md_out;
        md_c  = 1'b1;
        repeat (6) tick();
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        logic o, u;
        for (int i = n - 1; i >= 0; i--)
            mdc_cycle(v[i], o, u);
    endtask

    task automatic send_write(input int pre_n, input logic [4:0] phyad, input logic [4:0] regad,
                              input logic [15:0] data, input bit answer);
        logic o, u;
        oe_seen = 1'b0;
        if (answer)
            exp_q.push_back({1'b1, regad, data});
        for (int i = 0; i < pre_n; i++)
            mdc_cycle(1'b1, o, u);
        send_bits({2'b01, 2'b01, phyad, regad, 2'b10, data}, 32);
        check("wr_pending_strobes", exp_q.size(), 0);
        check("wr_no_drive", {31'd0, oe_seen}, 0);
    endtask

    task automatic read_frame(input int pre_n, input logic [4:0] phyad, input logic [4:0] regad,
                              input logic [15:0] val, input bit answer, input int rst_at);
        logic o, u;
        logic [15:0] word, oev;
        bit aborted;
        aborted = 1'b0;
        word    = '0;
        oev     = '0;
        rd_value = val;
        oe_seen  = 1'b0;
        if (answer)
            exp_q.push_back({1'b0, regad, 16'h0});
        for (int i = 0; i < pre_n; i++)
            mdc_cycle(1'b1, o, u);
        send_bits({18'd0, 2'b01, 2'b10, phyad, regad}, 14);
        check("rd_pending_strobes", exp_q.size(), 0);
        mdc_cycle(1'b1, o, u);
        check("ta1_oe", {31'd0, o}, 0);
        mdc_cycle(1'b1, o, u);
        check("ta2_pad", {30'd0, o, u}, answer ? 32'd2 : 32'd1);
        for (int i = 0; i < 16; i++) begin
            if (i == rst_at) begin
                md_c = 1'b0;
                repeat (4) tick();
                reset = 1'b1;
                tick();
                reset = 1'b0;
                check("rst_oe_next_clk", {31'd0, md_oe}, 0);
                oe_seen = 1'b0;
                repeat (8) tick();
                md_c = 1'b1;
                repeat (6) tick();
                check("rst_no_drive", {31'd0, oe_seen}, 0);
                aborted = 1'b1;
                break;
            end
            mdc_cycle(1'b1, o, u);
            word[15-i] = o ? u : 1'b1;
            oev[15-i]  = o;
        end
        if (!aborted) begin
            check("rd_data", {16'd0, word}, answer ? {16'd0, val} : 32'h0000FFFF);
            check("rd_data_oe", {16'd0, oev}, answer ? 32'h0000FFFF : 32'd0);
            mdc_cycle(1'b1, o, u);
            check("rd_release", {30'd0, o, u}, 32'd1);
            if (!answer)
                check("rd_no_drive", {31'd0, oe_seen}, 0);
        end
    endtask

    vec_t tbl[9];

    initial begin
        tbl[0] = '{1'b0, 32, 5'd1, 5'd4,  16'hA5C3, 1'b1};
        tbl[1] = '{1'b1, 32, 5'd1, 5'd2,  16'h796D, 1'b1};
        tbl[2] = '{1'b1, 32, 5'd3, 5'd2,  16'h1234, 1'b0};
        tbl[3] = '{1'b0, 32, 5'd1, 5'd7,  16'h0F0F, 1'b1};
        tbl[4] = '{1'b0, 32, 5'd0, 5'd8,  16'h0000, 1'b0};
        tbl[5] = '{1'b0, 31, 5'd1, 5'd9,  16'hBEEF, 1'b0};
        tbl[6] = '{1'b0, 32, 5'd1, 5'd9,  16'hBEEF, 1'b1};
        tbl[7] = '{1'b1, 32, 5'd1, 5'd31, 16'h8001, 1'b1};
        tbl[8] = '{1'b0, 40, 5'd1, 5'd0,  16'hFFFF, 1'b1};

        repeat (3) tick();
        check("rst_md_oe", {31'd0, md_oe}, 0);
        check("rst_md_out", {31'd0, md_out}, 1);
        check("rst_strobes", {30'd0, reg_rd, reg_wr}, 0);
        check("rst_reg_addr", {27'd0, reg_addr}, 0);
        check("rst_reg_wdata", {16'd0, reg_wdata}, 0);
        reset = 1'b0;
        repeat (3) tick();

        for (int k = 0; k < 9; k++) begin
            if (tbl[k].is_read)
                read_frame(tbl[k].pre_n, tbl[k].phyad, tbl[k].regad, tbl[k].data, tbl[k].answer, 16);
            else
                send_write(tbl[k].pre_n, tbl[k].phyad, tbl[k].regad, tbl[k].data, tbl[k].answer);
        end

        // reset during the read data phase, then a normal frame
        read_frame(32, 5'd1, 5'd3, 16'hF00F, 1'b1, 7);
        send_write(32, 5'd1, 5'd12, 16'h6A95, 1'b1);

        // back-to-back frames separated by a single idle bit
        send_write(32, 5'd1, 5'd5, 16'h1357, 1'b1);
        begin
            logic o, u;
            mdc_cycle(1'b1, o, u);
        end
        read_frame(0, 5'd1, 5'd6, 16'hC0DE, SUPP, 16);

        repeat (20) tick();
        check("final_scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdio_phy_responder.md
Name: mdio_phy_responder

Overview:
- PHY-side MII management (clause 22) responder: the far end of the MAC's MDC/MDIO management master.
- Decodes serial read/write frames on md_c/md_in and turns them into single-cycle register-file strobes on the system clock.
- Drives read data back on md_out/md_oe, which the top level ties to the bidirectional MDIO pad.
- Used as an in-FPGA PHY management model and for loopback bring-up of the MAC's management interface.

Parameters:
- PHY_ADDR, 5'd1, PHY address this block answers to.
- PREAMBLE_LEN, 32, consecutive 1 bits required before ST.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- md_c  input  1  management clock from the station; asynchronous to clk.
- md_in  input  1  MDIO pad input.
- md_out  output  1  MDIO drive value.
- md_oe  output  1  MDIO output enable; 1 = drive pad.
- reg_addr  output  5  register address of the current frame.
- reg_rd  output  1  one-clk read strobe.
- reg_rdata  input  16  register read data; valid 1 clk after reg_rd.
- reg_wr  output  1  one-clk write strobe.
- reg_wdata  output  16  register write data; valid while reg_wr=1.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high on port reset.
- Input synchronisation: md_c and md_in each pass through a 2-flop synchroniser on clk.
- Edge detection: a third md_c flop gives rise = sync & ~prev and fall = ~sync & prev.
- Bit sampling: a bit is the synchronised md_in in the clk cycle where rise=1.
- Constraints on md_c: high and low phases each >= 4 clk periods. md_out/md_oe change within 4 clk of a pin-level md_c falling edge.
- Reset values: md_oe=0, md_out=1, reg_rd=0, reg_wr=0, reg_addr=0, reg_wdata=0; state IDLE; preamble count 0; bit counter 0.
- Reset mid-frame: any state returns to IDLE, and md_oe drops on the first clk with reset=1 sampled.
- State IDLE:
  - Count consecutive sampled 1s, saturating at PREAMBLE_LEN.
  - A 0 with count==PREAMBLE_LEN is ST bit 1 -> ST2.
  - A 0 with count<PREAMBLE_LEN clears the count and stays in IDLE.
- State ST2: sampled 1 -> OP; sampled 0 -> IDLE.
- State OP: two bits. 10 = read, 01 = write; 00/11 -> IDLE.
- State PHYAD: 5 bits, MSB first, compared to PHY_ADDR after the 5th bit. Mismatch -> IDLE with no drive and no strobe.
- State REGAD: 5 bits, MSB first, shifted into reg_addr.
  - Read: reg_rd=1 for exactly the clk after the 5th REGAD rise.
  - Read: reg_rdata is captured into a 16-bit shift register on the following clk.
- State TA, read:
  - md_oe stays 0 through TA bit 1.
  - At the first fall after the TA bit-1 rise: md_oe=1, md_out=0.
  - At each of the next 16 falls, md_out = next data bit, MSB first.
  - At the fall after D0 has been presented for one full period: md_oe=0, md_out=1, -> IDLE with preamble count 0.
- State TA, write: two bits sampled, value ignored, md_oe held 0 -> WDATA.
- State WDATA:
  - 16 bits, MSB first, shifted into reg_wdata.
  - On the clk after the 16th rise: reg_wr=1 for one clk with reg_addr/reg_wdata stable, then -> IDLE.
- Strobe exclusivity: reg_rd and reg_wr are never both high; each is a single-clk pulse per frame.
- md_oe is 1 only in the read TA-bit-2 and RDATA periods.
- After any frame, a fresh preamble is required unless the optional feature is compiled in.
- Bit counter: 5-bit, cleared on every state transition.

Optional Feature:
- Macro: MDIO_PREAMBLE_SUPPRESS_EN.
- Defined: after a completed addressed frame, IDLE accepts ST following >= 1 idle 1 bit, i.e. preamble count is preloaded to PREAMBLE_LEN on frame completion. Reset and aborts still require a full preamble.
- Undefined: a full PREAMBLE_LEN preamble is required before every frame.

Test Plan:
- Write frame: 32x1, 01 01, PHYAD 00001, REGAD 00100, TA 10, data 16'hA5C3 -> exactly one reg_wr with reg_addr=4, reg_wdata=16'hA5C3; md_oe never 1.
- Read frame: REGAD 00010, reg_rdata=16'h796D -> one reg_rd with reg_addr=2. Station samples Z (md_oe=0) at TA1, 0 at TA2, then 0111100101101101. md_oe=0 after D0's period.
- PHYAD 00011 read -> no reg_rd, md_oe stays 0. A following correct frame is answered normally.
- 31-bit preamble then valid write -> ignored, no reg_wr. Same frame with 32 ones -> reg_wr.
- Reset asserted for 1 clk during RDATA bit 7 -> md_oe=0 the next clk, no strobes. Next full frame completes correctly.
- With MDIO_PREAMBLE_SUPPRESS_EN: write, then one 1 bit, then read with no preamble -> read answered. Without the macro the same read is ignored.
